uartlite_responder: RTL and testbench
=====================================

Name: uartlite_responder

Overview:
- AXI4-Lite responder exposing the UARTLite register map (RX FIFO, TX FIFO, STAT, CTRL), i.e. the target side of the bus our uart_wrapper master drives.
- Byte-stream side: TX FIFO drains to a valid/ready output; RX bytes are pushed in with a valid strobe.
- Used as a drop-in UARTLite replacement in simulation and as a custom peripheral in front of our own serializer.

Parameters:
- FIFO_DEPTH, 16, entries in each of the TX and RX FIFOs; power of two, at least 2.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- axi_awvalid/axi_awready  in/out  1/1  write-address handshake
- axi_awaddr  in  4  write byte address
- axi_awprot  in  3  ignored
- axi_wvalid/axi_wready  in/out  1/1  write-data handshake
- axi_wdata  in  32  write data; only bits [7:0] are used
- axi_wstrb  in  4  only bit 0 is honoured
- axi_bvalid/axi_bready  out/in  1/1  write-response handshake
- axi_bresp  out  2  always 2'b00 (OKAY)
- axi_arvalid/axi_arready  in/out  1/1  read-address handshake
- axi_araddr  in  4  read byte address
- axi_arprot  in  3  ignored
- axi_rvalid/axi_rready  out/in  1/1  read-data handshake
- axi_rdata  out  32  read data
- axi_rresp  out  2  always 2'b00
- tx_data  out  8  head byte of the TX FIFO
- tx_valid  out  1  TX FIFO is not empty
- tx_ready  in  1  consumer accepts tx_data
- rx_data  in  8  incoming byte
- rx_valid  in  1  one-cycle push strobe; there is no backpressure

Behaviour:
- Reset (async assert, sync release) clears the following:
  - awready, wready, arready, bvalid and rvalid go to 0.
  - rdata goes to 0.
  - Both FIFOs are emptied; the overrun flag and intr_en are cleared.
- Register map, decoded on addr[3:2]:
  - 0x0 RX: a read pops the head byte into rdata[7:0], upper bits 0. A read when RX is empty returns 0 and does not pop.
  - 0x4 TX: a write with wstrb[0]=1 pushes wdata[7:0]. A push when TX is full is dropped silently.
  - 0x8 STAT (read-only): bit0 rx_valid, bit1 rx_full, bit2 tx_empty, bit3 tx_full, bit4 intr_en, bit5 overrun, bits 6-7 and 31:8 are 0. Reading STAT clears overrun.
  - 0xC CTRL (write-only): bit0 flushes TX, bit1 flushes RX, bit4 sets intr_en.
  - Writes to 0x0 or 0x8 are ignored. Reads of 0x4 or 0xC return 0. All of these respond OKAY.
- Write channel:
  - awready=1 while no address is latched and bvalid=0; wready works the same way for data.
  - AW and W may arrive in either order or in the same cycle; each is latched independently.
  - The register effect is applied in the cycle after both are held.
  - bvalid rises in the same cycle the effect is applied and stays high until bready. The latches clear on the B handshake.
- Read channel:
  - arready=1 only while rvalid=0.
  - The cycle after the AR handshake, rvalid=1 with the data captured at that edge. Any RX pop occurs at that same edge.
  - rdata and rvalid are held stable until rready.
- TX FIFO:
  - Pops on tx_valid&tx_ready. tx_data is the registered head, so first-word latency is 1 cycle after the push.
  - If the FIFO is full, a pop and a push in the same cycle both take effect; the count is unchanged.
- RX FIFO:
  - rx_valid pushes when not full. Pushing into a full FIFO drops the byte and sets overrun.
  - A simultaneous bus pop and rx_valid push are both accepted, including when the FIFO is full.
- Flush priority: a CTRL flush in the same cycle as a push or pop wins, and the FIFO ends empty. An RX flush does not clear overrun.
- Pointers are log2(FIFO_DEPTH)+1 bits wide; full/empty are derived from MSB comparison, so wrap-around is exact.

Optional Feature:
- UARTLITE_RESPONDER_INTR_EN:
  - When defined, adds output port `interrupt` (1 bit, resets to 0).
  - The port pulses for one cycle when intr_en=1 and either RX goes from empty to non-empty or TX goes from non-empty to empty.
- When undefined: the port is absent, STAT bit4 still reflects intr_en, and no interrupt logic is built.

Test Plan:
- Write 0x41 to 0x4 with AW one cycle before W:
  - one B handshake, bresp=00;
  - tx_valid=1 with tx_data=0x41 the cycle after the effect;
  - tx_ready=1 clears tx_valid.
- Push 17 bytes 0x00..0x10 on rx_valid with FIFO_DEPTH=16:
  - STAT reads 0x23 (rx_valid, rx_full, overrun) and a second STAT read gives 0x03;
  - 16 RX reads return 0x00..0x0F, a 17th returns 0, and STAT ends 0x04.
- Hold tx_ready=0 and write 20 bytes:
  - STAT=0x08;
  - draining yields only the first 16 bytes in order.
- rvalid with rready=0 for 5 cycles:
  - rdata is stable and arready=0 throughout;
  - a simultaneous rx_valid push still lands.
- Write CTRL=0x03 with both FIFOs holding data and rx_valid asserted in the same cycle: STAT=0x04 afterwards.
- Assert rstn=0 mid-transaction (bvalid=1, TX non-empty): bvalid=0 and tx_valid=0 immediately, STAT=0x04 after release.

Source files
------------

// File: rtl/uartlite_responder.sv
// AXI4-Lite responder exposing the UARTLite register map (RX, TX, STAT, CTRL)
// in front of TX/RX byte FIFOs. Define UARTLITE_RESPONDER_INTR_EN to add the interrupt output.

module uartlite_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       flush,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       empty,
    output logic       full
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]  mem_q [DEPTH];
    logic [7:0]  mem_d [DEPTH];
    logic        do_pop, do_push;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q[AW-1:0]] = wdata;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end
endmodule

module uartlite_responder #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        axi_awvalid,
    output logic        axi_awready,
    input  logic [3:0]  axi_awaddr,
    input  logic [2:0]  axi_awprot,
    input  logic        axi_wvalid,
    output logic        axi_wready,
    input  logic [31:0] axi_wdata,
    input  logic [3:0]  axi_wstrb,
    output logic        axi_bvalid,
    input  logic        axi_bready,
    output logic [1:0]  axi_bresp,
    input  logic        axi_arvalid,
    output logic        axi_arready,
    input  logic [3:0]  axi_araddr,
    input  logic [2:0]  axi_arprot,
    output logic        axi_rvalid,
    input  logic        axi_rready,
    output logic [31:0] axi_rdata,
    output logic [1:0]  axi_rresp,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid
`ifdef UARTLITE_RESPONDER_INTR_EN
    ,
    output logic        interrupt
`endif
);
    localparam int NUM_FIFOS = 2;
    localparam int TX = 0;
    localparam int RX = 1;

    typedef struct packed {
        logic [1:0] addr;
        logic [7:0] data;
        logic       strb;
    } wr_req_t;

    wr_req_t     wreq_q, wreq_d;
    logic        aw_held_q, aw_held_d;
    logic        w_held_q, w_held_d;
    logic        awready_q, awready_d;
    logic        wready_q, wready_d;
    logic        bvalid_q, bvalid_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ovr_q, ovr_d;
    logic        ien_q, ien_d;

    logic [NUM_FIFOS-1:0]      f_flush, f_push, f_pop, f_empty, f_full;
    logic [NUM_FIFOS-1:0][7:0] f_wdata, f_rdata;

    logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic        wr_fire, wr_en, ctrl_wr;
    logic [31:0] stat, rd_mux;

    for (genvar g = 0; g < NUM_FIFOS; g++) begin : g_fifo
        uartlite_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (clk),
            .rstn  (rstn),
            .flush (f_flush[g]),
            .push  (f_push[g]),
            .pop   (f_pop[g]),
            .wdata (f_wdata[g]),
            .rdata (f_rdata[g]),
            .empty (f_empty[g]),
            .full  (f_full[g])
        );
    end

    assign aw_hs   = axi_awvalid && awready_q;
    assign w_hs    = axi_wvalid && wready_q;
    assign b_hs    = bvalid_q && axi_bready;
    assign ar_hs   = axi_arvalid && arready_q;
    assign r_hs    = rvalid_q && axi_rready;
    assign wr_fire = aw_held_q && w_held_q && !bvalid_q;
    assign wr_en   = wr_fire && wreq_q.strb;
    assign ctrl_wr = wr_en && (wreq_q.addr == 2'd3);

    assign stat = {26'd0, ovr_q, ien_q, f_full[TX], f_empty[TX], f_full[RX], !f_empty[RX]};

    always_comb begin
        f_flush[TX] = ctrl_wr && wreq_q.data[0];
        f_flush[RX] = ctrl_wr && wreq_q.data[1];
        f_push[TX]  = wr_en && (wreq_q.addr == 2'd1);
        f_push[RX]  = rx_valid;
        f_pop[TX]   = !f_empty[TX] && tx_ready;
        f_pop[RX]   = ar_hs && (axi_araddr[3:2] == 2'd0);
        f_wdata[TX] = wreq_q.data;
        f_wdata[RX] = rx_data;
    end

    always_comb begin
        case (axi_araddr[3:2])
            2'd0:    rd_mux = f_empty[RX] ? 32'd0 : {24'd0, f_rdata[RX]};
            2'd2:    rd_mux = stat;
            default: rd_mux = 32'd0;
        endcase
    end

    always_comb begin
        wreq_d    = wreq_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        bvalid_d  = bvalid_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        ovr_d     = ovr_q;
        ien_d     = ien_q;

        if (aw_hs) begin
            aw_held_d   = 1'b1;
            wreq_d.addr = axi_awaddr[3:2];
        end
        if (w_hs) begin
            w_held_d    = 1'b1;
            wreq_d.data = axi_wdata[7:0];
            wreq_d.strb = axi_wstrb[0];
        end
        if (wr_fire) begin
            bvalid_d = 1'b1;
        end else if (b_hs) begin
            bvalid_d  = 1'b0;
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
        end

        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_mux;
        end else if (r_hs) begin
            rvalid_d = 1'b0;
        end

        // A STAT read clears overrun, but a new overrun on the same edge is kept.
        if (ar_hs && (axi_araddr[3:2] == 2'd2)) ovr_d = 1'b0;
        if (rx_valid && f_full[RX] && !f_pop[RX] && !f_flush[RX]) ovr_d = 1'b1;
        if (ctrl_wr && wreq_q.data[4]) ien_d = 1'b1;

        awready_d = !aw_held_d && !bvalid_d;
        wready_d  = !w_held_d && !bvalid_d;
        arready_d = !rvalid_d;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wreq_q    <= '0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            ovr_q     <= 1'b0;
            ien_q     <= 1'b0;
        end else begin
            wreq_q    <= wreq_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            ovr_q     <= ovr_d;
            ien_q     <= ien_d;
        end
    end

`ifdef UARTLITE_RESPONDER_INTR_EN
    logic rx_empty_q, tx_empty_q, interrupt_q, interrupt_d;

    always_comb begin
        interrupt_d = ien_q && ((rx_empty_q && !f_empty[RX]) || (!tx_empty_q && f_empty[TX]));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_empty_q  <= 1'b1;
            tx_empty_q  <= 1'b1;
            interrupt_q <= 1'b0;
        end else begin
            rx_empty_q  <= f_empty[RX];
            tx_empty_q  <= f_empty[TX];
            interrupt_q <= interrupt_d;
        end
    end

    assign interrupt = interrupt_q;
`endif

    assign axi_awready = awready_q;
    assign axi_wready  = wready_q;
    assign axi_bvalid  = bvalid_q;
    assign axi_bresp   = 2'b00;
    assign axi_arready = arready_q;
    assign axi_rvalid  = rvalid_q;
    assign axi_rdata   = rdata_q;
    assign axi_rresp   = 2'b00;
    assign tx_data     = f_rdata[TX];
    assign tx_valid    = !f_empty[TX];

    logic unused_ok;
    assign unused_ok = ^{axi_awprot, axi_arprot, axi_awaddr[1:0], axi_araddr[1:0],
                         axi_wdata[31:8], axi_wstrb[3:1]};
endmodule

// File: tb/tb_uartlite_responder.sv
// Randomized bench for uartlite_responder: a queue-based register/FIFO model
// predicts read data and the TX stream, with directed scenarios pinning literal values.

module tb_uartlite_responder;
    localparam int D = 16;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        axi_awvalid = 0, axi_awready;
    logic [3:0]  axi_awaddr = 0;
    logic [2:0]  axi_awprot = 0;
    logic        axi_wvalid = 0, axi_wready;
    logic [31:0] axi_wdata = 0;
    logic [3:0]  axi_wstrb = 0;
    logic        axi_bvalid, axi_bready = 0;
    logic [1:0]  axi_bresp;
    logic        axi_arvalid = 0, axi_arready;
    logic [3:0]  axi_araddr = 0;
    logic [2:0]  axi_arprot = 0;
    logic        axi_rvalid, axi_rready = 0;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready = 0;
    logic [7:0]  rx_data = 0;
    logic        rx_valid = 0;

    always #5 clk = ~clk;

    uartlite_responder #(.FIFO_DEPTH(D)) dut (
        .clk(clk), .rstn(rstn),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
        .axi_awprot(axi_awprot), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_bvalid(axi_bvalid),
        .axi_bready(axi_bready), .axi_bresp(axi_bresp), .axi_arvalid(axi_arvalid),
        .axi_arready(axi_arready), .axi_araddr(axi_araddr), .axi_arprot(axi_arprot),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
        .axi_rresp(axi_rresp), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Behavioural model: FIFOs as queues plus the two status bits.
    logic [7:0]  tx_q[$];
    logic [7:0]  rx_q[$];
    bit          m_ovr = 0, m_ien = 0;
    bit          m_wr_now = 0, m_rd_now = 0, bg_rand = 0;
    logic [3:0]  m_waddr = 0, m_raddr = 0, m_wstrb = 0;
    logic [31:0] m_wdata = 0, m_rdata = 0;

    function automatic logic [31:0] stat_val();
        stat_val = {26'd0, m_ovr, m_ien, tx_q.size() == D, tx_q.size() == 0,
                    rx_q.size() == D, rx_q.size() != 0};
    endfunction

    // One clock: apply this cycle's bus/stream events to the model, advance, compare.
    task automatic step();
        bit txpop, rxpop, txpush, txfl, rxfl;
        if (bg_rand) begin
            rx_valid = ($urandom_range(0, 4) < 2);
            rx_data  = 8'($urandom);
            tx_ready = 1'($urandom_range(0, 1));
        end
        txpop = tx_ready && tx_q.size() > 0;
        rxpop = 0; txpush = 0; txfl = 0; rxfl = 0;
        if (m_rd_now) begin
            case (m_raddr[3:2])
                2'd0:    m_rdata = (rx_q.size() > 0) ? {24'd0, rx_q[0]} : 32'd0;
                2'd2:    m_rdata = stat_val();
                default: m_rdata = 32'd0;
            endcase
            rxpop = (m_raddr[3:2] == 2'd0) && rx_q.size() > 0;
            if (m_raddr[3:2] == 2'd2) m_ovr = 0;
        end
        if (m_wr_now && m_wstrb[0]) begin
            if (m_waddr[3:2] == 2'd1) txpush = 1;
            if (m_waddr[3:2] == 2'd3) begin
                txfl = m_wdata[0];
                rxfl = m_wdata[1];
                if (m_wdata[4]) m_ien = 1;
            end
        end
        if (txfl) tx_q.delete();
        else begin
            if (txpop) void'(tx_q.pop_front());
            if (txpush && tx_q.size() < D) tx_q.push_back(m_wdata[7:0]);
        end
        if (rxfl) rx_q.delete();
        else begin
            if (rxpop) void'(rx_q.pop_front());
            if (rx_valid) begin
                if (rx_q.size() < D) rx_q.push_back(rx_data);
                else m_ovr = 1;
            end
        end
        m_wr_now = 0;
        m_rd_now = 0;
        @(posedge clk);
        #1;
        chk("tx_valid", {31'd0, tx_valid}, {31'd0, tx_q.size() > 0});
        if (tx_q.size() > 0) chk("tx_data", {24'd0, tx_data}, {24'd0, tx_q[0]});
    endtask

    // mode: 0 = AW and W together, 1 = AW first, 2 = W first.
    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int mode, input int bdly, input bit rxv_eff, input logic [7:0] rxd_eff);
        axi_awaddr = addr; axi_wdata = data; axi_wstrb = strb;
        if (mode != 2) begin axi_awvalid = 1; chk("awready", {31'd0, axi_awready}, 1); end
        if (mode != 1) begin axi_wvalid = 1; chk("wready", {31'd0, axi_wready}, 1); end
        step();
        if (mode == 1) begin
            axi_awvalid = 0;
            chk("awready_held", {31'd0, axi_awready}, 0);
            axi_wvalid = 1;
            chk("wready", {31'd0, axi_wready}, 1);
            step();
        end else if (mode == 2) begin
            axi_wvalid = 0;
            chk("wready_held", {31'd0, axi_wready}, 0);
            axi_awvalid = 1;
            chk("awready", {31'd0, axi_awready}, 1);
            step();
        end
        axi_awvalid = 0; axi_wvalid = 0;
        chk("bvalid_pre", {31'd0, axi_bvalid}, 0);
        m_wr_now = 1; m_waddr = addr; m_wdata = data; m_wstrb = strb;
        if (rxv_eff) begin rx_valid = 1; rx_data = rxd_eff; end
        step();
        if (rxv_eff) rx_valid = 0;
        chk("bvalid", {31'd0, axi_bvalid}, 1);
        chk("bresp", {30'd0, axi_bresp}, 0);
        for (int i = 0; i < bdly; i++) begin
            step();
            chk("bvalid_hold", {31'd0, axi_bvalid}, 1);
        end
        axi_bready = 1;
        step();
        axi_bready = 0;
        chk("bvalid_clr", {31'd0, axi_bvalid}, 0);
    endtask

    task automatic axi_read(input logic [3:0] addr, input int stall, input bit push_in_stall,
                            output logic [31:0] got);
        axi_arvalid = 1; axi_araddr = addr;
        chk("arready", {31'd0, axi_arready}, 1);
        m_rd_now = 1; m_raddr = addr;
        step();
        axi_arvalid = 0;
        chk("rvalid", {31'd0, axi_rvalid}, 1);
        chk("rdata", axi_rdata, m_rdata);
        chk("rresp", {30'd0, axi_rresp}, 0);
        got = axi_rdata;
        for (int i = 0; i < stall; i++) begin
            if (push_in_stall && i == 0) begin rx_valid = 1; rx_data = 8'h77; end
            step();
            if (push_in_stall && i == 0) rx_valid = 0;
            chk("rvalid_hold", {31'd0, axi_rvalid}, 1);
            chk("rdata_hold", axi_rdata, m_rdata);
            chk("arready_stall", {31'd0, axi_arready}, 0);
        end
        axi_rready = 1;
        step();
        axi_rready = 0;
        chk("rvalid_clr", {31'd0, axi_rvalid}, 0);
    endtask

    task automatic rx_push(input logic [7:0] b);
        rx_valid = 1; rx_data = b;
        step();
        rx_valid = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] got;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_awready", {31'd0, axi_awready}, 0);
        chk("rst_wready", {31'd0, axi_wready}, 0);
        chk("rst_arready", {31'd0, axi_arready}, 0);
        chk("rst_bvalid", {31'd0, axi_bvalid}, 0);
        chk("rst_rvalid", {31'd0, axi_rvalid}, 0);
        chk("rst_rdata", axi_rdata, 0);
        chk("rst_tx_valid", {31'd0, tx_valid}, 0);
        @(negedge clk) rstn = 1;
        @(posedge clk);
        #1;
        chk("post_rst_awready", {31'd0, axi_awready}, 1);
        chk("post_rst_arready", {31'd0, axi_arready}, 1);

        // Single TX write, AW a cycle before W.
        axi_write(4'h4, 32'h41, 4'hF, 1, 2, 0, 8'h0);
        chk("t1_tx_valid", {31'd0, tx_valid}, 1);
        chk("t1_tx_data", {24'd0, tx_data}, 32'h41);
        tx_ready = 1;
        step();
        tx_ready = 0;
        chk("t1_tx_drained", {31'd0, tx_valid}, 0);

        // RX overrun with one byte parked in TX.
        axi_write(4'h4, 32'hEE, 4'h1, 0, 0, 0, 8'h0);
        for (int i = 0; i <= 16; i++) rx_push(8'(i));
        axi_read(4'h8, 0, 0, got); chk("t2_stat_ovr", got, 32'h23);
        axi_read(4'h8, 0, 0, got); chk("t2_stat_clr", got, 32'h03);
        tx_ready = 1; step(); tx_ready = 0;
        for (int i = 0; i < 16; i++) begin
            axi_read(4'h0, 0, 0, got);
            chk("t2_rx_byte", got, i);
        end
        axi_read(4'h0, 0, 0, got); chk("t2_rx_empty", got, 0);
        axi_read(4'h8, 0, 0, got); chk("t2_stat_end", got, 32'h04);

        // TX overfill: only the first 16 survive.
        for (int i = 0; i < 20; i++) axi_write(4'h4, 32'h30 + i, 4'h1, i % 3, 0, 0, 8'h0);
        axi_read(4'h8, 0, 0, got); chk("t3_stat_full", got, 32'h08);
        tx_ready = 1;
        for (int i = 0; i < 16; i++) begin
            chk("t3_drain_valid", {31'd0, tx_valid}, 1);
            chk("t3_drain_data", {24'd0, tx_data}, 32'h30 + i);
            step();
        end
        tx_ready = 0;
        chk("t3_drain_done", {31'd0, tx_valid}, 0);

        // Read data stall with an RX push landing during it.
        rx_push(8'h55);
        rx_push(8'h66);
        axi_read(4'h0, 5, 1, got); chk("t4_first", got, 32'h55);
        axi_read(4'h0, 0, 0, got); chk("t4_second", got, 32'h66);
        axi_read(4'h0, 0, 0, got); chk("t4_stall_push", got, 32'h77);

        // Dual flush with a colliding rx_valid.
        axi_write(4'h4, 32'hA1, 4'h1, 0, 0, 0, 8'h0);
        axi_write(4'h4, 32'hA2, 4'h1, 0, 0, 0, 8'h0);
        rx_push(8'h11);
        rx_push(8'h12);
        axi_write(4'hC, 32'h03, 4'h1, 0, 0, 1, 8'h13);
        axi_read(4'h8, 0, 0, got); chk("t5_stat_flush", got, 32'h04);

        // Reset asserted with bvalid high and TX non-empty.
        axi_awaddr = 4'h4; axi_wdata = 32'h99; axi_wstrb = 4'h1;
        axi_awvalid = 1; axi_wvalid = 1;
        step();
        axi_awvalid = 0; axi_wvalid = 0;
        m_wr_now = 1; m_waddr = 4'h4; m_wdata = 32'h99; m_wstrb = 4'h1;
        step();
        chk("t6_bvalid_pre", {31'd0, axi_bvalid}, 1);
        #2 rstn = 0;
        #1;
        chk("t6_rst_bvalid", {31'd0, axi_bvalid}, 0);
        chk("t6_rst_tx_valid", {31'd0, tx_valid}, 0);
        tx_q.delete(); rx_q.delete(); m_ovr = 0; m_ien = 0;
        @(negedge clk) rstn = 1;
        @(posedge clk);
        #1;
        chk("t6_awready", {31'd0, axi_awready}, 1);
        axi_read(4'h8, 0, 0, got); chk("t6_stat", got, 32'h04);

        // Randomized traffic against the model.
        bg_rand = 1;
        for (int n = 0; n < 400; n++) begin
            int r, a;
            logic [3:0] addr;
            logic [31:0] data;
            r = $urandom_range(0, 9);
            if (r < 4) begin
                a = $urandom_range(0, 19);
                addr = (a < 12) ? 4'h4 : (a < 15) ? 4'hC : (a < 17) ? 4'h0 : 4'h8;
                data = $urandom;
                if (addr == 4'hC && $urandom_range(0, 2) != 0) data = data & 32'hFFFF_FFEC;
                axi_write(addr, data, ($urandom_range(0, 5) == 0) ? 4'hE : 4'(($urandom) | 1),
                          $urandom_range(0, 2), $urandom_range(0, 2), 0, 8'h0);
            end else if (r < 8) begin
                a = $urandom_range(0, 9);
                addr = (a < 4) ? 4'h0 : (a < 7) ? 4'h8 : (a < 8) ? 4'h4 : 4'hC;
                addr[1:0] = 2'($urandom);
                axi_read(addr, $urandom_range(0, 2), 0, got);
            end else begin
                step();
            end
        end
        bg_rand = 0;
        rx_valid = 0;
        tx_ready = 0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
